// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and grant selection for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int STAT_BITS = 16;
    localparam int LOCK_BITS = 4;

    // Round-robin pick: on contention the requester that was not last served wins.
    function automatic arb_state_t arb_pick(input logic r0, input logic r1, input logic last);
        arb_state_t s;
        if (r0 && r1) begin
            s = last ? OWN0 : OWN1;
        end else if (r0) begin
            s = OWN0;
        end else if (r1) begin
            s = OWN1;
        end else begin
            s = IDLE;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arb_stat_cnt.sv
// rtl/mem_arb_stat_cnt.sv - saturating grant-cycle counter with sync active-low clear
module mem_arb_stat_cnt
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 inc,
    output logic [STAT_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {STAT_BITS{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter with bounded lock for a shared memory
// Optional grant statistics outputs gcnt0/gcnt1 when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 8,
    parameter int LOCK_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 lock0,
    input  logic                 lock1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_BITS-1:0] adr0,
    input  logic [ADDR_BITS-1:0] adr1,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic [WIDTH-1:0]     wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [WIDTH-1:0]     rdata,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_BITS-1:0] gcnt0,
    output logic [STAT_BITS-1:0] gcnt1
`endif
);

    localparam logic [LOCK_BITS-1:0] LOCK_LIM = LOCK_BITS'(LOCK_MAX);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic                 last;
    logic [LOCK_BITS-1:0] lockcnt;
    logic [LOCK_BITS-1:0] lockcnt_nxt;
    logic                 own_we;
    logic                 rd0_done;
    logic                 rd1_done;

    // Retention rules first; anything else falls back to the round-robin pick.
    always_comb begin
        state_nxt   = arb_pick(req0, req1, last);
        lockcnt_nxt = '0;
        case (state)
            OWN0: begin
                if (req0 && lock0 && (lockcnt < LOCK_LIM)) begin
                    state_nxt   = OWN0;
                    lockcnt_nxt = lockcnt + 1'b1;
                end else if (req0 && !req1) begin
                    state_nxt   = OWN0;
                    lockcnt_nxt = lock0 ? lockcnt : '0;
                end
            end
            OWN1: begin
                if (req1 && lock1 && (lockcnt < LOCK_LIM)) begin
                    state_nxt   = OWN1;
                    lockcnt_nxt = lockcnt + 1'b1;
                end else if (req1 && !req0) begin
                    state_nxt   = OWN1;
                    lockcnt_nxt = lock1 ? lockcnt : '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            lockcnt <= '0;
        end else begin
            state   <= state_nxt;
            lockcnt <= lockcnt_nxt;
            if (state_nxt == OWN0) begin
                last <= 1'b0;
            end else if (state_nxt == OWN1) begin
                last <= 1'b1;
            end
        end
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        own_we    = 1'b0;
        case (state)
            OWN0: begin
                mem_adr   = adr0;
                mem_wdata = wdata0;
                own_we    = we0;
            end
            OWN1: begin
                mem_adr   = adr1;
                mem_wdata = wdata1;
                own_we    = we1;
            end
            default: begin
            end
        endcase
    end

    // Gating with reset kills a write in the very cycle reset is asserted.
    assign mem_we = own_we & reset;

    assign rd0_done = gnt0 && !we0;
    assign rd1_done = gnt1 && !we1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= rd0_done;
            rvalid1 <= rd1_done;
            if (rd0_done || rd1_done) begin
                rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    mem_arb_stat_cnt u_gcnt0 (
        .clk   (clk),
        .clr_n (reset),
        .inc   (gnt0),
        .count (gcnt0)
    );

    mem_arb_stat_cnt u_gcnt1 (
        .clk   (clk),
        .clr_n (reset),
        .inc   (gnt1),
        .count (gcnt1)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a negedge memory model
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, lock0, lock1, we0, we1;
    logic [7:0] adr0, adr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       mem_we;
    logic [7:0] mem_adr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_adr = 8'h00;
    logic [7:0] pre_dat = 8'h00;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(8), .ADDR_BITS(8), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .we0       (we0),
        .we1       (we1),
        .adr0      (adr0),
        .adr1      (adr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
`endif
    );

    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_wdata;
        end else if (pre_we) begin
            mem[pre_adr] <= pre_dat;
        end
        mem_rdata <= mem[mem_adr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
            else chk("rdata0", {24'h0, rdata}, {24'h0, q0.pop_front()});
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
            else chk("rdata1", {24'h0, rdata}, {24'h0, q1.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_adr = a;
        pre_dat = d;
        pre_we  = 1'b1;
        @(negedge clk);
        #1;
        pre_we  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {req0, req1, lock0, lock1, we0, we1} = '0;
        {adr0, adr1, wdata0, wdata1} = '0;
        preload(8'h10, 8'h3C);
        preload(8'h20, 8'hA5);
        preload(8'h30, 8'h5A);
        preload(8'h40, 8'h11);
        preload(8'h41, 8'h22);
        preload(8'h50, 8'h33);
        preload(8'h51, 8'h44);
        preload(8'h60, 8'h77);
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        reset = 1'b1;
        tick();
        chk("idle_gnt0", gnt0, 0);
        chk("idle_mem_adr", mem_adr, 0);

        // single read by requester 1
        adr1 = 8'h10; we1 = 1'b0; req1 = 1'b1; q1.push_back(8'h3C);
        tick();
        chk("sr_gnt1", gnt1, 1);
        chk("sr_gnt0", gnt0, 0);
        chk("sr_mem_adr", mem_adr, 8'h10);
        req1 = 1'b0;
        tick();
        chk("sr_gnt1_off", gnt1, 0);
        chk("sr_rvalid1", rvalid1, 1);
        tick();
        chk("sr_rvalid1_off", rvalid1, 0);

        // contention from a fresh reset: 0 first, then 1
        reset = 1'b0;
        tick();
        reset = 1'b1;
        adr0 = 8'h20; adr1 = 8'h30; req0 = 1'b1; req1 = 1'b1;
        q0.push_back(8'hA5); q1.push_back(8'h5A);
        tick();
        chk("ct_c1_gnt0", gnt0, 1);
        chk("ct_c1_gnt1", gnt1, 0);
        req0 = 1'b0;
        tick();
        chk("ct_c2_gnt1", gnt1, 1);
        chk("ct_c2_gnt0", gnt0, 0);
        chk("ct_c2_rvalid0", rvalid0, 1);
        req1 = 1'b0;
        tick();
        chk("ct_c3_rvalid1", rvalid1, 1);
        chk("ct_c3_gnt1", gnt1, 0);
        tick();

        // alternation without lock
        adr0 = 8'h40; adr1 = 8'h41; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("alt_gnt0_%0d", i), gnt0, (i % 2 == 0));
            chk($sformatf("alt_gnt1_%0d", i), gnt1, (i % 2 == 1));
            if (i % 2 == 0) q0.push_back(8'h11);
            else q1.push_back(8'h22);
            if (i == 4) req0 = 1'b0;
            if (i == 5) req1 = 1'b0;
        end
        tick();
        tick();

        // lock bound: five grants to 0, forced hand-over to 1, then back to 0
        adr0 = 8'h50; adr1 = 8'h51; req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("lock_gnt0_%0d", i), gnt0, (i != 5));
            chk($sformatf("lock_gnt1_%0d", i), gnt1, (i == 5));
            if (i == 5) begin
                q1.push_back(8'h44);
                req1 = 1'b0;
            end else begin
                q0.push_back(8'h33);
            end
            if (i == 6) begin
                req0 = 1'b0;
                lock0 = 1'b0;
            end
        end
        tick();
        tick();

        // write by requester 0
        chk("wr_idle_mem_we", mem_we, 0);
        we0 = 1'b1; adr0 = 8'hFF; wdata0 = 8'h0D; req0 = 1'b1;
        tick();
        chk("wr_gnt0", gnt0, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_adr", mem_adr, 8'hFF);
        chk("wr_mem_wdata", mem_wdata, 8'h0D);
        req0 = 1'b0;
        tick();
        we0 = 1'b0;
        chk("wr_mem_we_off", mem_we, 0);
        chk("wr_no_rvalid0", rvalid0, 0);
        chk("wr_mem_ff", mem[8'hFF], 8'h0D);

        // read back the written byte through requester 1
        adr1 = 8'hFF; req1 = 1'b1; q1.push_back(8'h0D);
        tick();
        chk("rb_gnt1", gnt1, 1);
        req1 = 1'b0;
        tick();
        chk("rb_rvalid1", rvalid1, 1);
        tick();

        // reset asserted inside a write grant cycle
        we1 = 1'b1; adr1 = 8'h60; wdata1 = 8'hEE; req1 = 1'b1;
        tick();
        chk("ra_gnt1", gnt1, 1);
        chk("ra_mem_we_pre", mem_we, 1);
        reset = 1'b0;
        #1;
        chk("ra_mem_we_gated", mem_we, 0);
        tick();
        chk("ra_gnt0", gnt0, 0);
        chk("ra_gnt1", gnt1, 0);
        chk("ra_rvalid0", rvalid0, 0);
        chk("ra_rvalid1", rvalid1, 0);
        chk("ra_mem_60", mem[8'h60], 8'h77);
`ifdef MEM_ARB_STATS_EN
        chk("ra_gcnt0", gcnt0, 0);
        chk("ra_gcnt1", gcnt1, 0);
`endif
        req1 = 1'b0; we1 = 1'b0; reset = 1'b1;
        tick();
        tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 8-bit external memory (negedge-write, negedge-registered read) between the MIPS core (requester 0) and a program loader/debug port (requester 1).
- Sits between the requesters and the memory. Drives memory address, write data and write enable from the current owner.
- Uses round-robin arbitration with an optional bounded lock for bursts.
- Returns registered read data with a valid pulse.

Parameters:
- WIDTH, 8, data width of memory and requester ports.
- ADDR_BITS, 8, memory address width.
- LOCK_MAX, 4, maximum consecutive locked grants before a forced hand-over when the other requester is waiting (1..15).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- req0, req1  input  1 each  access request, held until granted.
- lock0, lock1  input  1 each  owner requests to keep the grant for its next back-to-back access.
- we0, we1  input  1 each  1 = write, 0 = read.
- adr0, adr1  input  ADDR_BITS each  access address.
- wdata0, wdata1  input  WIDTH each  write data.
- gnt0, gnt1  output  1 each  registered; high marks the cycle in which that requester's access is performed.
- rvalid0, rvalid1  output  1 each  registered; pulses one cycle after a granted read.
- rdata  output  WIDTH  registered read data, shared by both requesters, qualified by rvalidN.
- mem_we  output  1  memory write enable.
- mem_adr  output  ADDR_BITS  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory read data.

Behaviour:
- Reset (reset==0 at posedge):
  - gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0.
  - State IDLE, last-served pointer=1 (requester 0 favoured first), lock counter=0.
- States: IDLE (no owner), OWN0, OWN1. Exactly one of gnt0/gnt1 is high in OWNn; neither is high in IDLE. gntN == (state==OWNN).
- Next-state decision at each posedge:
  - Keep the current owner n if req_n && lock_n && lockcnt<LOCK_MAX.
  - Also keep owner n if req_n and the other requester is not requesting.
  - Otherwise grant the requesting requester that was not last served. If only one requests, grant it.
  - If neither requests, go to IDLE.
- Lock counter:
  - Increments on each consecutive locked retention.
  - Clears on owner change or IDLE.
  - At LOCK_MAX with the other requester waiting, ownership is forced over.
  - If the other requester is not waiting, the owner keeps the grant regardless.
- Latency and handshake:
  - A request first seen at posedge k gets its earliest grant in cycle k+1.
  - The requester holds req/we/adr/wdata stable until it sees gntN.
  - The gnt cycle is the access cycle.
  - Keeping req high during the gnt cycle requests a further access; new adr/we/wdata must be presented in the following cycle.
- Memory drive, combinational from the owner:
  - mem_adr = adr_owner, mem_wdata = wdata_owner, mem_we = gnt & we_owner & reset.
  - In IDLE all three are 0.
  - The write completes at the negedge inside the gnt cycle.
- Read return:
  - At the posedge ending a read gnt cycle: rdata <= mem_rdata and rvalidN <= 1 for one cycle.
  - A write gnt produces no rvalid; rdata holds its previous value.
- Simultaneous first requests from IDLE after reset: requester 0 wins, then requester 1.
- Reset low mid-access: mem_we is gated off immediately in that cycle, so no write occurs. The next posedge clears all state. An in-flight read gets no rvalid.
- Illegal input: req low while granted ends ownership at the next posedge. The current-cycle access still executes.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs gcnt0, gcnt1 (16 bits each).
  - Each counts gnt cycles of its requester and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding constants IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Stat counter width constant STAT_BITS=16.
- Sub-module mem_arb_stat_cnt: saturating STAT_BITS counter with sync active-low clear and an increment enable. It is instantiated twice, only under MEM_ARB_STATS_EN.

Test Plan:
- Single read: req1 with adr1=8'h10 and mem[10]=8'h3C, req0 idle -> gnt1 high one cycle later; the following cycle rvalid1=1 and rdata=8'h3C; gnt1 and rvalid1 low after.
- Contention: req0 and req1 both high from IDLE after reset, each doing a single read -> gnt0 in cycle 1 and gnt1 in cycle 2; rvalid0 in cycle 2 and rvalid1 in cycle 3.
- Alternation: req0 and req1 held high for 6 cycles with lock low -> grant sequence 0,1,0,1,0,1.
- Lock bound: LOCK_MAX=4 with lock0/req0 held and req1 high -> 5 consecutive gnt0 (1 plus 4 retentions), then gnt1.
- Write: req0 writes we0=1, adr0=8'hFF, wdata0=8'h0D -> mem_we high only in the gnt0 cycle and mem[FF]=8'h0D; no rvalid0.
- Reset abort: reset driven low during a gnt1 write cycle -> mem_we=0 in that cycle, mem unchanged, and gnt/rvalid all 0 at the next posedge. With MEM_ARB_STATS_EN defined, gcnt0 and gcnt1 are also 0.
